// File: rtl/mips_ifetch_unit.sv
// mips_ifetch_unit: instruction fetch for the single-cycle MIPS core.
// Holds the PC, fetches one word at a time over a req/ack handshake, latches it
// into the IR and offers it to decode over valid/ready. Redirects and the PC
// advance happen only when the instruction retires.
// Optional feature macro: IFETCH_ILLEGAL_TRAP_EN. When it is defined, a fetched
// word with an unsupported opcode parks the unit in S_HALT until reset.
module mips_ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [5:0]       opcode,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             illegal_op
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_r;
    logic [31:0]        pc_r;
    logic [31:0]        ir_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               req_r;
    logic               valid_r;
    logic [31:0]        pc_plus4_s;
    logic [31:0]        next_pc_s;

`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic               illegal_r;

    // Only R-type, beq, lw and sw are executed by the core.
    function automatic logic opcode_legal(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd4) || (op == 6'd35) || (op == 6'd43);
    endfunction
`endif

    assign pc_plus4_s = pc_r + 32'd4;

    // Retire target: redirect address is forced word-aligned, otherwise fall through.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (branch_taken) begin
            next_pc_s = branch_target & 32'hFFFF_FFFC;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Fetch FSM with registered handshake flags; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_REQ;
            pc_r      <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            cnt_r     <= '0;
            req_r     <= 1'b1;
            valid_r   <= 1'b0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
            illegal_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_REQ: begin
                    if (imem_ack) begin
                        ir_r    <= imem_rdata;
                        req_r   <= 1'b0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
                        if (!opcode_legal(imem_rdata[31:26])) begin
                            state_r   <= S_HALT;
                            valid_r   <= 1'b0;
                            illegal_r <= 1'b1;
                        end else begin
                            state_r   <= S_HOLD;
                            valid_r   <= 1'b1;
                        end
`else
                        state_r <= S_HOLD;
                        valid_r <= 1'b1;
`endif
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        pc_r    <= next_pc_s;
                        state_r <= S_REQ;
                        req_r   <= 1'b1;
                        valid_r <= 1'b0;
                    end
                end
`ifdef IFETCH_ILLEGAL_TRAP_EN
                S_HALT: begin
                    req_r     <= 1'b0;
                    valid_r   <= 1'b0;
                    illegal_r <= 1'b1;
                end
`endif
                default: begin
                    state_r <= S_REQ;
                    req_r   <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = valid_r;
    assign instr       = ir_r;
    assign opcode      = ir_r[31:26];
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign retired_cnt = cnt_r;
`ifdef IFETCH_ILLEGAL_TRAP_EN
    assign illegal_op  = illegal_r;
`else
    assign illegal_op  = 1'b0;
`endif

endmodule

// File: tb/tb_mips_ifetch_unit.sv
// Testbench for mips_ifetch_unit: random memory latency / decode back-pressure /
// branches, with a scoreboard of expected retirements checked by a monitor.
module tb_mips_ifetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;
    localparam int          TB_CNT_W    = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_ack = 1'b0;
    logic [31:0]         imem_rdata = 32'h0;
    logic                instr_valid;
    logic                instr_ready = 1'b0;
    logic [31:0]         instr;
    logic [5:0]          opcode;
    logic [31:0]         pc;
    logic [31:0]         pc_plus4;
    logic                branch_taken = 1'b0;
    logic [31:0]         branch_target = 32'h0;
    logic [TB_CNT_W-1:0] retired_cnt;
    logic                illegal_op;

    mips_ifetch_unit #(.RESET_PC(TB_RESET_PC), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .retired_cnt(retired_cnt), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] model_pc;
    int   model_cnt;
    bit   prev_ack;
    bit   prev_retire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
`ifdef IFETCH_ILLEGAL_TRAP_EN
        case ($urandom_range(0, 3))
            0:       w[31:26] = 6'd0;
            1:       w[31:26] = 6'd4;
            2:       w[31:26] = 6'd35;
            default: w[31:26] = 6'd43;
        endcase
`endif
        return w;
    endfunction

    // One cycle of memory / decode behaviour. br_mode: -1 random, 0 no branch, 1 branch to tgt.
    task automatic step_cycle(input int p_ack, input int p_ready, input int br_mode,
                              input logic [31:0] tgt, input logic [31:0] word);
        @(negedge clk);
        if (prev_ack) begin
            check("ack_to_valid", {30'd0, instr_valid, imem_req}, 32'h2);
        end
        if (prev_retire) begin
            check("retire_to_req", {30'd0, instr_valid, imem_req}, 32'h1);
        end
        prev_ack      = 1'b0;
        prev_retire   = 1'b0;
        imem_ack      = 1'b0;
        instr_ready   = 1'b0;
        imem_rdata    = $urandom;
        branch_taken  = 1'($urandom_range(0, 1));
        branch_target = $urandom;
        if (imem_req) begin
            check("imem_addr", imem_addr, model_pc);
            if (int'($urandom_range(0, 99)) < p_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = word;
                exp_q.push_back('{word, model_pc, (model_cnt + 1) % (1 << TB_CNT_W)});
                prev_ack   = 1'b1;
            end
        end else begin
            imem_ack = 1'($urandom_range(0, 1));
        end
        if (instr_valid && int'($urandom_range(0, 99)) < p_ready) begin
            instr_ready = 1'b1;
            if (br_mode == 0) begin
                branch_taken = 1'b0;
            end else if (br_mode == 1) begin
                branch_taken  = 1'b1;
                branch_target = tgt;
            end else if ($urandom_range(0, 3) == 0) begin
                branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            model_pc    = branch_taken ? (branch_target & 32'hFFFF_FFFC) : model_pc + 32'd4;
            model_cnt   = (model_cnt + 1) % (1 << TB_CNT_W);
            prev_retire = 1'b1;
        end
    endtask

    // Monitor: every retirement must match the oldest fetched word and its address.
    always @(posedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL retire_unexpected: got instr %h expected none", instr);
            end else begin
                e = exp_q.pop_front();
                check("instr", instr, e.word);
                check("opcode", {26'd0, opcode}, {26'd0, e.word[31:26]});
                check("pc", pc, e.addr);
                check("pc_plus4", pc_plus4, e.addr + 32'd4);
                #1;
                check("retired_cnt", {28'd0, retired_cnt}, 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [31:0] h_instr;
        logic [31:0] h_pc;
        logic [31:0] h_cnt;
        int          guard;
        model_pc    = TB_RESET_PC;
        model_cnt   = 0;
        prev_ack    = 1'b0;
        prev_retire = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd1);
        check("rst_imem_addr", imem_addr, TB_RESET_PC);
        check("rst_retired_cnt", {28'd0, retired_cnt}, 32'd0);
        check("rst_illegal_op", {31'd0, illegal_op}, 32'd0);
        check("rst_instr", instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First fetch: memory waits three cycles, then returns a lw word
        repeat (3) step_cycle(0, 0, 0, 32'd0, 32'd0);
        step_cycle(100, 0, 0, 32'd0, 32'h8C01_0004);
        step_cycle(0, 0, 0, 32'd0, 32'd0);
        check("first_opcode", {26'd0, opcode}, 32'd35);
        check("first_pc", pc, TB_RESET_PC);

        // Sequential retires without branches, including the pc wrap to 0
        repeat (8) step_cycle(100, 100, 0, 32'd0, rand_word());

        // Branch to an unaligned target
        guard = 0;
        while (!instr_valid && guard < 20) begin
            step_cycle(100, 0, 0, 32'd0, rand_word());
            guard++;
        end
        step_cycle(0, 100, 1, 32'h0000_0043, 32'd0);
        step_cycle(0, 0, 0, 32'd0, 32'd0);
        check("branch_addr", imem_addr, 32'h0000_0040);
        check("branch_pc_plus4", pc_plus4, 32'h0000_0044);

        // Back-pressure: IR, pc and count hold while ack/branch toggle
        guard = 0;
        while (!instr_valid && guard < 20) begin
            step_cycle(100, 0, 0, 32'd0, rand_word());
            guard++;
        end
        h_instr = instr;
        h_pc    = pc;
        h_cnt   = {28'd0, retired_cnt};
        repeat (10) begin
            step_cycle(100, 0, -1, $urandom, rand_word());
            check("hold_instr", instr, h_instr);
            check("hold_pc", pc, h_pc);
            check("hold_cnt", {28'd0, retired_cnt}, h_cnt);
            check("hold_req", {30'd0, instr_valid, imem_req}, 32'h2);
        end

        // Random traffic
        repeat (600) step_cycle(60, 50, -1, $urandom, rand_word());

        // Asynchronous reset while an instruction is held
        guard = 0;
        while (!instr_valid && guard < 20) begin
            step_cycle(100, 0, 0, 32'd0, rand_word());
            guard++;
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_imem_req", {31'd0, imem_req}, 32'd1);
        check("arst_imem_addr", imem_addr, TB_RESET_PC);
        check("arst_retired_cnt", {28'd0, retired_cnt}, 32'd0);
        exp_q.delete();
        model_pc    = TB_RESET_PC;
        model_cnt   = 0;
        prev_ack    = 1'b0;
        prev_retire = 1'b0;
        @(negedge clk);
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        reset       = 1'b0;
        repeat (40) step_cycle(70, 70, -1, $urandom, rand_word());

`ifdef IFETCH_ILLEGAL_TRAP_EN
        // Illegal opcode parks the unit until reset
        guard = 0;
        while (!imem_req && guard < 20) begin
            step_cycle(0, 100, 0, 32'd0, 32'd0);
            guard++;
        end
        h_pc = model_pc;
        @(negedge clk);
        imem_ack    = 1'b1;
        imem_rdata  = 32'hFC00_0000;
        instr_ready = 1'b1;
        prev_ack    = 1'b0;
        prev_retire = 1'b0;
        repeat (5) begin
            @(negedge clk);
            imem_ack = 1'b1;
            check("halt_illegal_op", {31'd0, illegal_op}, 32'd1);
            check("halt_valid_req", {30'd0, instr_valid, imem_req}, 32'd0);
            check("halt_pc", pc, h_pc);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
